// File: rtl/mem_access_stage.sv
// Memory-access pipeline stage sitting directly behind the execute-stage ALU.
// ALU ops are forwarded to writeback with one cycle of latency. Aligned LW/SW
// become a single data-memory transaction over a req/ack handshake, and the
// stage stalls upstream (ready_in=0) until that transaction completes or
// times out. Illegal (LW and SW together) and misaligned accesses are
// rejected locally with an error pulse and never reach memory.
//
// Handshakes:
//   upstream : an op transfers on a rising clk edge where valid_in && ready_in;
//              ready_in depends only on state, never on valid_in.
//   memory   : mem_req rises and mem_addr/mem_we/mem_wdata are held stable
//              until the edge where mem_ack is seen high; mem_req drops the
//              cycle after. mem_ack is only looked at while a request is
//              outstanding, so a stray or late ack is ignored.
//   writeback: valid_out, wb_en and err are one-cycle pulses; wb_data and
//              wb_rd hold their last value between pulses.

module mem_access_stage #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              valid_in,
  output logic              ready_in,
  input  logic              is_load,
  input  logic              is_store,
  input  logic [ADDR_W-1:0] alu_result,
  input  logic [DATA_W-1:0] store_data,
  input  logic [4:0]        rd_in,
  input  logic              reg_write_in,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic              valid_out,
  output logic [DATA_W-1:0] wb_data,
  output logic [4:0]        wb_rd,
  output logic              wb_en,
  output logic              err
);

  // Counter is sized to hold TIMEOUT itself so it can saturate instead of wrap.
  localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  state_t            state;
  logic [CNT_W-1:0]  cnt;
  logic [4:0]        rd_q;
  logic              reg_write_q;

  logic              accept;
  logic              is_mem;
  logic              illegal;
  logic              misaligned;
  logic              reject;
  logic              ack_hit;
  logic              at_limit;
  logic [DATA_W-1:0] alu_as_data;

  assign ready_in    = (state == IDLE);
  assign accept      = valid_in && ready_in;
  assign is_mem      = is_load || is_store;
  assign illegal     = is_load && is_store;
  assign misaligned  = is_mem && (alu_result[1:0] != 2'b00);
  assign reject      = illegal || misaligned;
  // Only an ack that arrives while the request is actually out counts.
  assign ack_hit     = mem_req && mem_ack;
  assign at_limit    = (cnt == CNT_LAST);
  assign alu_as_data = DATA_W'(alu_result);

  // Stage controller: op decode, memory transaction, timeout and writeback pulses.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      cnt         <= '0;
      rd_q        <= '0;
      reg_write_q <= 1'b0;
      mem_req     <= 1'b0;
      mem_we      <= 1'b0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
      valid_out   <= 1'b0;
      wb_data     <= '0;
      wb_rd       <= '0;
      wb_en       <= 1'b0;
      err         <= 1'b0;
    end else begin
      // Pulse outputs fall back to 0 unless a branch below raises them.
      valid_out <= 1'b0;
      wb_en     <= 1'b0;
      err       <= 1'b0;

      case (state)
        IDLE: begin
          if (accept) begin
            if (reject) begin
              // Illegal or misaligned: answer immediately, memory untouched.
              valid_out <= 1'b1;
              err       <= 1'b1;
              wb_rd     <= rd_in;
            end else if (!is_mem) begin
              // ALU op: stay in IDLE so the next op can follow back-to-back.
              valid_out <= 1'b1;
              wb_data   <= alu_as_data;
              wb_rd     <= rd_in;
              wb_en     <= reg_write_in;
            end else begin
              mem_req     <= 1'b1;
              mem_we      <= is_store;
              mem_addr    <= alu_result;
              mem_wdata   <= is_store ? store_data : '0;
              rd_q        <= rd_in;
              reg_write_q <= reg_write_in;
              cnt         <= '0;
              state       <= ACCESS;
            end
          end
        end

        ACCESS: begin
          if (ack_hit) begin
            // Ack wins even on the last allowed cycle.
            mem_req   <= 1'b0;
            state     <= RESP;
            valid_out <= 1'b1;
            wb_rd     <= rd_q;
            if (!mem_we) begin
              wb_data <= mem_rdata;
              wb_en   <= reg_write_q;
            end else begin
              wb_data <= '0;
            end
          end else if (at_limit) begin
            // Memory never answered: abandon the request and report it.
            mem_req   <= 1'b0;
            state     <= RESP;
            valid_out <= 1'b1;
            err       <= 1'b1;
            wb_rd     <= rd_q;
          end else if (cnt != CNT_MAX) begin
            cnt <= cnt + CNT_W'(1);
          end
        end

        RESP: begin
          // Writeback pulse is on the outputs during this cycle.
          state <= IDLE;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_stage.sv
// Bench for mem_access_stage: directed scenarios followed by randomized ops.
// A transaction-level model predicts each writeback (expected queue) and a
// separate memory responder answers the DUT's requests.

module tb_mem_access_stage;

  localparam int TO = 4;
  localparam int W  = 41;  // {chk_data, chk_rd, err, wb_en, rd[4:0], data[31:0]}

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic        valid_in;
  logic        ready_in;
  logic        is_load;
  logic        is_store;
  logic [31:0] alu_result;
  logic [31:0] store_data;
  logic [4:0]  rd_in;
  logic        reg_write_in;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ack;
  logic        valid_out;
  logic [31:0] wb_data;
  logic [4:0]  wb_rd;
  logic        wb_en;
  logic        err;

  mem_access_stage #(
    .ADDR_W (32),
    .DATA_W (32),
    .TIMEOUT(TO)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .valid_in    (valid_in),
    .ready_in    (ready_in),
    .is_load     (is_load),
    .is_store    (is_store),
    .alu_result  (alu_result),
    .store_data  (store_data),
    .rd_in       (rd_in),
    .reg_write_in(reg_write_in),
    .mem_req     (mem_req),
    .mem_we      (mem_we),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_rdata   (mem_rdata),
    .mem_ack     (mem_ack),
    .valid_out   (valid_out),
    .wb_data     (wb_data),
    .wb_rd       (wb_rd),
    .wb_en       (wb_en),
    .err         (err)
  );

  // ---------------- scoreboard state ----------------
  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;
  logic [W-1:0] exp_q[$];
  logic [31:0]  model_mem [logic [31:0]];  // architectural memory seen by the model
  logic [31:0]  resp_mem  [logic [31:0]];  // memory behind the responder

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Writeback monitor: every valid_out pulse must match the oldest prediction.
  always @(negedge clk) begin
    logic [W-1:0] e;
    if (rst_n) begin
      if (err && !valid_out)   check("err_without_valid", 64'(err), 64'(0));
      if (wb_en && !valid_out) check("wb_en_without_valid", 64'(wb_en), 64'(0));
      if (valid_out) begin
        if (exp_q.size() == 0) begin
          check("unexpected_valid_out", 64'(valid_out), 64'(0));
        end else begin
          e = exp_q.pop_front();
          check("wb_err", 64'(err), 64'(e[38]));
          check("wb_en", 64'(wb_en), 64'(e[37]));
          if (e[39]) check("wb_rd", 64'(wb_rd), 64'(e[36:32]));
          if (e[40]) check("wb_data", 64'(wb_data), 64'(e[31:0]));
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic scramble_inputs();
    is_load      = 1'($urandom);
    is_store     = 1'($urandom);
    alu_result   = $urandom;
    store_data   = $urandom;
    rd_in        = 5'($urandom);
    reg_write_in = 1'($urandom);
  endtask

  // Apply one op from IDLE (called at posedge+1) and play memory with the ack
  // arriving ack_dly cycles after mem_req rises; returns at posedge+1 in IDLE.
  task automatic send_op(input logic ld, input logic st, input logic [31:0] a,
                         input logic [31:0] d, input logic [4:0] rd, input logic rw,
                         input int ack_dly);
    logic         bad;
    logic         mem_op;
    logic         acked;
    logic [W-1:0] e;
    logic [31:0]  ld_val;
    mem_op = ld | st;
    bad    = (ld & st) | (mem_op & (a[1:0] != 2'b00));
    if (bad) begin
      e = {1'b0, 1'b0, 1'b1, 1'b0, 5'd0, 32'd0};
    end else if (!mem_op) begin
      e = {1'b1, 1'b1, 1'b0, rw, rd, a};
    end else if (ack_dly >= TO) begin
      e = {1'b0, 1'b0, 1'b1, 1'b0, 5'd0, 32'd0};
    end else if (st) begin
      model_mem[a] = d;
      e = {1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0};
    end else begin
      ld_val = model_mem.exists(a) ? model_mem[a] : 32'd0;
      e = {1'b1, 1'b1, 1'b0, rw, rd, ld_val};
    end

    valid_in = 1'b1; is_load = ld; is_store = st; alu_result = a;
    store_data = d; rd_in = rd; reg_write_in = rw;
    @(negedge clk);
    check("ready_in_idle", 64'(ready_in), 64'(1));
    exp_q.push_back(e);
    @(posedge clk); #1;
    valid_in = 1'b0;
    scramble_inputs();

    if (bad || !mem_op) begin
      @(negedge clk);
      check("direct_valid_out", 64'(valid_out), 64'(1));
      check("direct_no_req", 64'(mem_req), 64'(0));
      check("direct_ready_in", 64'(ready_in), 64'(1));
      @(posedge clk); #1;
    end else begin
      acked = 1'b0;
      for (int i = 0; i < TO; i++) begin
        if (i == ack_dly) begin
          acked     = 1'b1;
          mem_ack   = 1'b1;
          mem_rdata = resp_mem.exists(mem_addr) ? resp_mem[mem_addr] : 32'd0;
        end else begin
          mem_ack   = 1'b0;
          mem_rdata = $urandom;
        end
        @(negedge clk);
        check("mem_req_held", 64'(mem_req), 64'(1));
        check("mem_addr", 64'(mem_addr), 64'(a));
        check("mem_we", 64'(mem_we), 64'(st));
        check("mem_wdata", 64'(mem_wdata), st ? 64'(d) : 64'(0));
        check("ready_in_busy", 64'(ready_in), 64'(0));
        check("no_valid_during_access", 64'(valid_out), 64'(0));
        if (acked && mem_req && mem_we) resp_mem[mem_addr] = mem_wdata;
        @(posedge clk); #1;
        mem_ack = 1'b0;
        if (acked) break;
      end
      @(negedge clk);
      check("resp_valid_out", 64'(valid_out), 64'(1));
      check("resp_req_dropped", 64'(mem_req), 64'(0));
      check("resp_ready_in", 64'(ready_in), 64'(0));
      @(posedge clk); #1;
      @(negedge clk);
      check("post_resp_ready_in", 64'(ready_in), 64'(1));
      check("post_resp_valid_out", 64'(valid_out), 64'(0));
      @(posedge clk); #1;
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a;
    logic        ld;
    logic        st;
    int          kind;

    rst_n = 1'b0; valid_in = 1'b0; mem_ack = 1'b0; mem_rdata = '0;
    scramble_inputs();
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // Reset state
    @(negedge clk);
    check("rst_ready_in", 64'(ready_in), 64'(1));
    check("rst_mem_req", 64'(mem_req), 64'(0));
    check("rst_mem_we", 64'(mem_we), 64'(0));
    check("rst_mem_addr", 64'(mem_addr), 64'(0));
    check("rst_mem_wdata", 64'(mem_wdata), 64'(0));
    check("rst_valid_out", 64'(valid_out), 64'(0));
    check("rst_wb_data", 64'(wb_data), 64'(0));
    check("rst_wb_rd", 64'(wb_rd), 64'(0));
    check("rst_wb_en", 64'(wb_en), 64'(0));
    check("rst_err", 64'(err), 64'(0));
    @(posedge clk); #1;

    // ALU passthrough, two ops back-to-back
    valid_in = 1'b1; is_load = 1'b0; is_store = 1'b0;
    alu_result = 32'h0000_0005; rd_in = 5'd3; reg_write_in = 1'b1;
    exp_q.push_back({1'b1, 1'b1, 1'b0, 1'b1, 5'd3, 32'h5});
    @(negedge clk);
    check("b2b_ready_first", 64'(ready_in), 64'(1));
    @(posedge clk); #1;
    alu_result = 32'h0000_1234; rd_in = 5'd4; reg_write_in = 1'b0;
    exp_q.push_back({1'b1, 1'b1, 1'b0, 1'b0, 5'd4, 32'h1234});
    @(negedge clk);
    check("b2b_ready_second", 64'(ready_in), 64'(1));
    check("b2b_valid_first", 64'(valid_out), 64'(1));
    @(posedge clk); #1;
    valid_in = 1'b0;
    @(negedge clk);
    check("b2b_valid_second", 64'(valid_out), 64'(1));
    @(posedge clk); #1;
    @(negedge clk);
    check("b2b_valid_ends", 64'(valid_out), 64'(0));
    @(posedge clk); #1;

    // Store with ack two cycles after mem_req, then load hit on first cycle
    send_op(1'b0, 1'b1, 32'h100, 32'hDEAD_BEEF, 5'd9, 1'b1, 2);
    send_op(1'b1, 1'b0, 32'h100, 32'h0, 5'd7, 1'b1, 0);

    // Misaligned load and illegal load+store
    send_op(1'b1, 1'b0, 32'h102, 32'h0, 5'd5, 1'b1, 0);
    send_op(1'b1, 1'b1, 32'h100, 32'h0, 5'd6, 1'b1, 0);

    // Timeout (no ack at all) and ack on the last allowed cycle
    send_op(1'b0, 1'b1, 32'h104, 32'h1111_2222, 5'd1, 1'b0, 99);
    send_op(1'b1, 1'b0, 32'h104, 32'h0, 5'd2, 1'b1, TO - 1);
    send_op(1'b0, 1'b1, 32'h108, 32'hCAFE_F00D, 5'd3, 1'b0, TO - 1);
    send_op(1'b1, 1'b0, 32'h108, 32'h0, 5'd8, 1'b1, 1);

    // Reset while a store is outstanding; later ack must be ignored
    valid_in = 1'b1; is_load = 1'b0; is_store = 1'b1;
    alu_result = 32'h300; store_data = 32'h5555_AAAA; rd_in = 5'd10; reg_write_in = 1'b0;
    @(posedge clk); #1;
    valid_in = 1'b0;
    @(negedge clk);
    check("midrst_req_up", 64'(mem_req), 64'(1));
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("midrst_req_dropped", 64'(mem_req), 64'(0));
    check("midrst_ready_in", 64'(ready_in), 64'(1));
    check("midrst_no_valid", 64'(valid_out), 64'(0));
    mem_ack = 1'b1;
    mem_rdata = 32'h0BAD_0BAD;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("stray_ack_no_req", 64'(mem_req), 64'(0));
      check("stray_ack_no_valid", 64'(valid_out), 64'(0));
      check("stray_ack_ready", 64'(ready_in), 64'(1));
    end
    @(posedge clk); #1;
    mem_ack = 1'b0;

    // Randomized ops against the model
    for (int n = 0; n < 60; n++) begin
      kind = $urandom_range(0, 9);
      a = 32'h200 + 32'(4 * $urandom_range(0, 7));
      if ($urandom_range(0, 5) == 0) a = a + 32'($urandom_range(1, 3));
      ld = 1'b0; st = 1'b0;
      if (kind <= 2) begin
        a = $urandom;
      end else if (kind <= 5) begin
        ld = 1'b1;
      end else if (kind <= 8) begin
        st = 1'b1;
      end else begin
        ld = 1'b1; st = 1'b1;
      end
      send_op(ld, st, a, $urandom, 5'($urandom_range(0, 31)),
              1'($urandom_range(0, 1)), $urandom_range(0, TO + 1));
    end

    @(negedge clk);
    check("exp_q_drained", 64'(exp_q.size()), 64'(0));
    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_access_stage.md
Name: mem_access_stage

Overview:
- Memory-access stage directly downstream of the execute-stage ALU.
- Consumes the ALU result and either forwards it to writeback (ALU ops, e.g. ADDI) or uses it as a word address for a load/store (LW/SW) to data memory.
- Talks to data memory over a req/ack handshake.
- Stalls upstream while an access is outstanding and raises an error on misalignment, illegal op or timeout.

Parameters:
- ADDR_W, 32, width of the ALU result / memory address
- DATA_W, 32, data word width
- TIMEOUT, 16, max cycles to wait for mem_ack before aborting (>=1)

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  synchronous active-low reset
- valid_in  in  1  upstream op valid
- ready_in  out  1  stage can accept an op this cycle
- is_load  in  1  op is LW
- is_store  in  1  op is SW
- alu_result  in  ADDR_W  ALU output: writeback value or memory address
- store_data  in  DATA_W  rs2 value for SW
- rd_in  in  5  destination register
- reg_write_in  in  1  op writes rd
- mem_req  out  1  memory request
- mem_we  out  1  1 = write, 0 = read
- mem_addr  out  ADDR_W  memory byte address
- mem_wdata  out  DATA_W  write data
- mem_rdata  in  DATA_W  read data, valid when mem_ack=1
- mem_ack  in  1  memory completion
- valid_out  out  1  one-cycle writeback pulse
- wb_data  out  DATA_W  writeback value
- wb_rd  out  5  writeback register
- wb_en  out  1  register write enable (only meaningful with valid_out)
- err  out  1  one-cycle error pulse, coincident with valid_out

Behaviour:
- Reset (rst_n=0 at a clk edge) forces the following; any outstanding access is abandoned, and a late mem_ack after reset is ignored:
  - state IDLE, timeout counter 0
  - mem_req, mem_we, valid_out, wb_en and err all 0
  - mem_addr, mem_wdata, wb_data and wb_rd all 0
  - ready_in=1 once rst_n=1
- States are IDLE, ACCESS and RESP.
- ready_in = (state==IDLE), combinational. An op is accepted on a clk edge with valid_in && ready_in.
- IDLE, accept with is_load=is_store=0 (ALU op):
  - Next cycle valid_out=1, wb_data=alu_result, wb_rd=rd_in, wb_en=reg_write_in, err=0.
  - State stays IDLE, so back-to-back ALU ops sustain 1 op/cycle at 1-cycle latency.
- IDLE, accept with is_load and is_store both 1:
  - Illegal op. Next cycle valid_out=1, err=1, wb_en=0.
  - No memory request is issued.
- IDLE, accept of a load/store with alu_result[1:0]!=0:
  - Misaligned. Next cycle valid_out=1, err=1, wb_en=0.
  - No memory request is issued.
- IDLE, accept of an aligned load/store:
  - Register mem_addr=alu_result, mem_we=is_store, mem_wdata=store_data (0 for loads), rd and reg_write.
  - Next cycle mem_req=1 and state=ACCESS; counter cleared.
- ACCESS:
  - mem_req, mem_addr, mem_we and mem_wdata are held stable until the ack.
  - On mem_ack=1: drop mem_req next cycle, go to RESP, and capture mem_rdata for a load.
  - Without ack: counter increments. When the counter reaches TIMEOUT-1 with no ack, the next cycle drops mem_req, goes to RESP and flags a timeout.
  - An ack on the same cycle the counter reaches TIMEOUT-1 counts as success; the ack wins.
- RESP: lasts one cycle, with valid_out=1, then returns to IDLE.
  - Load success: wb_data=captured rdata, wb_en=saved reg_write, err=0.
  - Store success: wb_en=0, err=0, wb_data=0.
  - Timeout: wb_en=0, err=1.
- Load/store latency: accept at edge N, mem_req high from N+1, ack seen at edge M, valid_out during cycle M+1. ready_in returns to 1 in the cycle after RESP.
- mem_ack while mem_req=0 is ignored.
- valid_out, err and wb_en are single-cycle pulses. wb_data and wb_rd hold their last value otherwise.
- No arithmetic beyond the counter. The counter is wide enough for TIMEOUT and saturates; it never wraps.

Test Plan:
- ALU op passthrough: reset, then accept alu_result=0x0000_0005, rd_in=3, reg_write_in=1 -> next cycle valid_out=1, wb_data=5, wb_rd=3, wb_en=1, err=0. A second op on the following cycle is accepted (ready_in stays 1).
- Store: accept is_store, alu_result=0x100, store_data=0xDEADBEEF; memory acks 2 cycles after mem_req rises -> mem_req=1, mem_we=1, mem_addr=0x100, mem_wdata=0xDEADBEEF held until ack. Then valid_out=1, wb_en=0, err=0. ready_in=0 throughout ACCESS and RESP.
- Load after store: is_load, alu_result=0x100, rd_in=7, memory returns 0xDEADBEEF with ack on the first cycle -> mem_we=0, then valid_out=1, wb_data=0xDEADBEEF, wb_rd=7, wb_en=1.
- Misaligned and illegal ops: is_load with alu_result=0x102 -> no mem_req, next cycle valid_out=1, err=1, wb_en=0. Repeat with is_load=is_store=1 and alu_result=0x100 -> same response.
- Timeout: TIMEOUT=4, mem_ack held 0 -> mem_req high for exactly 4 cycles, then valid_out=1, err=1, wb_en=0, and ready_in=1 on the following cycle. Repeat with the ack on the 4th cycle -> err=0.
- Reset mid-access: drive rst_n=0 for one edge while in ACCESS -> mem_req=0, ready_in=1 after release, no valid_out. A later stray mem_ack produces no output.
